bitcoin_result_reader: RTL and testbench
========================================

Name: bitcoin_result_reader

Overview:
Reads back the per-nonce H0 words that the bitcoin hash engine writes to memory, starting at output_addr, one 32-bit word per nonce. It issues a read burst over the shared single-port memory interface and compares every H0 against a difficulty target. It reports the hit mask, the hit count, and the nonce with the minimum H0. It sits after the hash engine, which it normally follows directly on the engine's done.

Parameters:
NUM_NONCE, 16, number of result words to read (nonces 0..NUM_NONCE-1), range 1..16
ADDR_W, 16, memory address width

Ports:
clk  in  1  single clock; all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  request a read-back; sampled only in IDLE
output_addr  in  ADDR_W  base address of nonce-0 H0 word; latched at start
target  in  32  difficulty threshold; latched at start; hit when H0 < target (unsigned)
mem_clk  out  1  equals clk
mem_we  out  1  constant 0
mem_addr  out  ADDR_W  read address
mem_write_data  out  32  constant 0
mem_read_data  in  32  synchronous-read data, valid the cycle after its address is driven
busy  out  1  high while in READ
done  out  1  one-cycle pulse when results are valid
found  out  1  at least one hit
hit_count  out  5  number of hits (0..16)
hit_mask  out  16  bit n set if H0[n] < target; bits >= NUM_NONCE are 0
best_nonce  out  4  nonce of the minimum H0
best_hash  out  32  minimum H0 value

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - All outputs and internal registers go to 0, except mem_clk, which follows clk.
  - Takes effect immediately, including mid-burst. No done is generated for an aborted run.
- States: IDLE -> READ -> IDLE.
  - done is registered on the transition out of READ.
  - There is no separate DONE state.
- IDLE:
  - When start=1 at edge T, latch output_addr and target.
  - Clear found, hit_count, hit_mask and best_nonce to 0. Set best_hash to 0xFFFF_FFFF.
  - Set addr_ctr=0, rd_ctr=0, busy=1, state=READ.
- READ:
  - mem_addr = base + addr_ctr, with the sum wrapping at ADDR_W.
  - Each edge while addr_ctr < NUM_NONCE: addr_ctr++. After that, addr_ctr holds at NUM_NONCE and mem_addr holds base+NUM_NONCE-1.
  - From edge T+2 onward, each edge captures the word for rd_ctr and then does rd_ctr++.
  - Word for nonce n is captured at edge T+n+2.
- Per captured word w for nonce n, all updates in the same edge:
  - If w < target: hit_mask[n]=1 and hit_count++.
  - If w < best_hash (strict): best_hash=w and best_nonce=n. On ties, the lower nonce wins.
  - The first word always replaces the initial best, including w=0xFFFF_FFFF, which ties and then forces best_nonce=0 via an rd_ctr==0 override.
- Completion:
  - The edge capturing nonce NUM_NONCE-1 (edge T+NUM_NONCE+1) sets done=1, busy=0, state=IDLE.
  - found = (hit_count != 0), registered.
  - done drops on the next edge.
- Latency: done is high in the cycle after edge T+NUM_NONCE+1, i.e. 17 edges for the default NUM_NONCE.
- Result outputs hold their values until the next accepted start.
- start while busy is ignored.
- start high in the done cycle is accepted, because state is already IDLE.
- Changes to output_addr and target after the start edge have no effect on the current run.
- target=0 means no hits are possible. best_* are still reported.

Decomposition:
- bitcoin_pkg holds:
  - the state enum (IDLE, READ)
  - NUM_NONCE_DEFAULT=16
  - ADDR_W_DEFAULT=16
  - the nonce index type (logic [3:0])
- Sub-module bitcoin_min_tracker holds the registered best_hash/best_nonce update with tie and first-word rules. It takes clear, valid, word and index as inputs.
- The counters, FSM and memory drive stay in the top level.

Test Plan:
1. H0[n]=0xF000_0000-n, target=0x0000_1000, start at edge T -> done only in the cycle after T+17; found=0, hit_count=0, hit_mask=0x0000, best_nonce=15, best_hash=0xEFFF_FFF1; mem_addr sequence base..base+15 with mem_we=0 throughout.
2. H0[5]=0x0000_0ABC, others 0xFFFF_FFFF, target=0x0000_1000 -> found=1, hit_count=1, hit_mask=0x0020, best_nonce=5, best_hash=0x0000_0ABC.
3. H0[3]=H0[9]=0x0000_0001, others 0x8000_0000, target=0x0000_0002 -> hit_count=2, hit_mask=0x0208, best_nonce=3 (tie keeps the lower nonce).
4. H0[0]=0x0000_1000=target, others 0xFFFF_0000 -> found=0, hit_mask=0 (strict compare), best_nonce=0, best_hash=0x0000_1000. Separately, all words 0xFFFF_FFFF -> best_nonce=0.
5. reset_n low at edge T+7 -> busy, all results and mem_addr are 0 immediately, and no done follows. Then reset_n high, start, with data from scenario 2 -> scenario-2 results at edge +17.
6. start held high for 30 cycles and output_addr changed at T+4 -> exactly one run at the original base. The start seen in the done cycle starts a second run: results clear at its start edge, and it produces a second done 17 edges later.

Source files
------------

// File: rtl/bitcoin_result_reader_pkg.sv
// bitcoin_pkg: shared state encoding, default sizes and nonce index type for the result reader
package bitcoin_pkg;
    typedef enum logic {IDLE, READ} state_t;
    localparam int NUM_NONCE_DEFAULT = 16;
    localparam int ADDR_W_DEFAULT = 16;
    typedef logic [3:0] nonce_t;
endpackage

// File: rtl/bitcoin_result_reader_if.sv
// bitcoin_result_reader_if: single-port memory bus shared with the hash engine
//   mem_clk        memory clock (driven by master, equals its clk)
//   mem_we         write enable (reader never writes)
//   mem_addr       address
//   mem_write_data write data (unused by reader)
//   mem_read_data  synchronous-read data, valid the cycle after its address
interface bitcoin_result_reader_if
    import bitcoin_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
);
    logic              mem_clk;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;
    modport master (output mem_clk, mem_we, mem_addr, mem_write_data, input mem_read_data);
    modport slave  (input mem_clk, mem_we, mem_addr, mem_write_data, output mem_read_data);
endinterface

// File: rtl/bitcoin_result_reader_min_tracker.sv
// bitcoin_min_tracker: registered running minimum of captured H0 words and its nonce
//   clk, reset_n  clock, async active-low reset (clears to 0)
//   clear         start of run: best_hash <= all ones, best_nonce <= 0
//   valid, word, index  one captured word and its nonce
//   best_hash, best_nonce  current minimum and the lowest nonce holding it
module bitcoin_min_tracker
    import bitcoin_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        valid,
    input  logic [31:0] word,
    input  nonce_t      index,
    output logic [31:0] best_hash,
    output nonce_t      best_nonce
);
    // Strict compare keeps the lower nonce on ties; nonce 0 always loads so an
    // all-ones first word still reports nonce 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            best_hash  <= '0;
            best_nonce <= '0;
        end else if (clear) begin
            best_hash  <= '1;
            best_nonce <= '0;
        end else if (valid && (word < best_hash || index == '0)) begin
            best_hash  <= word;
            best_nonce <= index;
        end
    end
endmodule

// File: rtl/bitcoin_result_reader.sv
// bitcoin_result_reader: burst-reads per-nonce H0 words and reports hits against a target and the minimum
//   clk, reset_n        clock, async active-low reset
//   start               begin a read-back (accepted only when idle)
//   output_addr, target base address and difficulty threshold, latched at start
//   mem                 memory bus master (read-only)
//   busy, done          run in progress, one-cycle completion pulse
//   found, hit_count, hit_mask  hit summary (H0 < target)
//   best_nonce, best_hash       minimum H0 and its nonce
module bitcoin_result_reader
    import bitcoin_pkg::*;
#(
    parameter int NUM_NONCE = NUM_NONCE_DEFAULT,
    parameter int ADDR_W    = ADDR_W_DEFAULT
)(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        output_addr,
    input  logic [31:0]              target,
    bitcoin_result_reader_if.master  mem,
    output logic                     busy,
    output logic                     done,
    output logic                     found,
    output logic [4:0]               hit_count,
    output logic [15:0]              hit_mask,
    output nonce_t                   best_nonce,
    output logic [31:0]              best_hash
);
    localparam logic [4:0] N    = 5'(NUM_NONCE);
    localparam logic [4:0] LAST = 5'(NUM_NONCE - 1);

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [31:0]       tgt;
    logic [4:0]        addr_ctr;
    logic [4:0]        rd_ctr;
    logic              accept;
    logic              capture;
    logic              hit;
    logic [4:0]        cnt_nxt;

    assign accept  = state == IDLE && start;
    // Data for address k arrives one cycle after it is driven, so capture
    // begins once the address counter has moved past its first value.
    assign capture = state == READ && addr_ctr != '0;
    assign hit     = mem.mem_read_data < tgt;
    assign cnt_nxt = hit_count + 5'(hit);

    assign mem.mem_clk        = clk;
    assign mem.mem_we         = 1'b0;
    assign mem.mem_write_data = '0;
    assign mem.mem_addr       = base + ADDR_W'(addr_ctr == N ? LAST : addr_ctr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            base      <= '0;
            tgt       <= '0;
            addr_ctr  <= '0;
            rd_ctr    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            found     <= 1'b0;
            hit_count <= '0;
            hit_mask  <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                base      <= output_addr;
                tgt       <= target;
                found     <= 1'b0;
                hit_count <= '0;
                hit_mask  <= '0;
                addr_ctr  <= '0;
                rd_ctr    <= '0;
                busy      <= 1'b1;
                state     <= READ;
            end else if (state == READ) begin
                if (addr_ctr < N)
                    addr_ctr <= addr_ctr + 5'd1;
                if (capture) begin
                    hit_mask  <= hit_mask | (16'(hit) << rd_ctr[3:0]);
                    hit_count <= cnt_nxt;
                    rd_ctr    <= rd_ctr + 5'd1;
                    if (rd_ctr == LAST) begin
                        found <= cnt_nxt != '0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
            end
        end
    end

    bitcoin_min_tracker u_min (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (accept),
        .valid      (capture),
        .word       (mem.mem_read_data),
        .index      (rd_ctr[3:0]),
        .best_hash  (best_hash),
        .best_nonce (best_nonce)
    );
endmodule

// File: tb/tb_bitcoin_result_reader.sv
// tb_bitcoin_result_reader: scoreboard bench for bitcoin_result_reader with a synchronous-read memory model
module tb_bitcoin_result_reader;
    typedef struct packed {
        logic        found;
        logic [4:0]  cnt;
        logic [15:0] mask;
        logic [3:0]  bn;
        logic [31:0] bh;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] output_addr = '0;
    logic [31:0] target = '0;
    logic        busy, done, found;
    logic [4:0]  hit_count;
    logic [15:0] hit_mask;
    logic [3:0]  best_nonce;
    logic [31:0] best_hash;

    logic [31:0] ram [0:65535];
    logic [31:0] w [16];
    exp_t        q [$];
    int          tests = 0;
    int          fails = 0;

    bitcoin_result_reader_if #(.ADDR_W(16)) mem_if ();

    bitcoin_result_reader #(.NUM_NONCE(16), .ADDR_W(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .output_addr (output_addr),
        .target      (target),
        .mem         (mem_if.master),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .hit_count   (hit_count),
        .hit_mask    (hit_mask),
        .best_nonce  (best_nonce),
        .best_hash   (best_hash)
    );

    always #5 clk = ~clk;

    always @(posedge mem_if.mem_clk) mem_if.mem_read_data <= ram[mem_if.mem_addr];

    // Scoreboard: every done pops one expected result.
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done at %0t: got done=1, required no pending run", $time);
            end else begin
                e = q.pop_front();
                if ({found, hit_count, hit_mask, best_nonce, best_hash} !== e) begin
                    fails++;
                    $display("FAIL result at %0t: got found=%0b cnt=%0d mask=%h bn=%0d bh=%h, required found=%0b cnt=%0d mask=%h bn=%0d bh=%h",
                             $time, found, hit_count, hit_mask, best_nonce, best_hash, e.found, e.cnt, e.mask, e.bn, e.bh);
                end
            end
        end
    end

    task automatic load_and_expect(input logic [15:0] b, input logic [31:0] tg);
        exp_t e;
        logic [15:0] a;
        e = '0;
        e.bh = w[0];
        for (int n = 0; n < 16; n++) begin
            a = b + 16'(n);
            ram[a] = w[n];
            if (w[n] < tg) begin
                e.mask[n] = 1'b1;
                e.cnt++;
            end
            if (w[n] < e.bh) begin
                e.bh = w[n];
                e.bn = 4'(n);
            end
        end
        e.found = e.cnt != 0;
        q.push_back(e);
    endtask

    // Pulses start for one edge; k returns the edge count from the start edge to done (40 on timeout).
    task automatic pulse_and_wait(input logic [15:0] b, input logic [31:0] tg, output int k);
        output_addr = b;
        target = tg;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, done, found, hit_count, hit_mask, best_nonce, best_hash, mem_if.mem_addr, mem_if.mem_we} !== '0) begin
            fails++;
            $display("FAIL reset_state: got busy=%0b done=%0b found=%0b cnt=%0d mask=%h bn=%0d bh=%h addr=%h we=%0b, required all 0",
                     busy, done, found, hit_count, hit_mask, best_nonce, best_hash, mem_if.mem_addr, mem_if.mem_we);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_no_hits();
        logic [15:0] b = 16'h0100;
        for (int n = 0; n < 16; n++) w[n] = 32'hF000_0000 - 32'(n);
        load_and_expect(b, 32'h0000_1000);
        output_addr = b;
        target = 32'h0000_1000;
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            tests++;
            if (mem_if.mem_we !== 1'b0 || mem_if.mem_write_data !== 32'd0) begin
                fails++;
                $display("FAIL no_write k=%0d: got we=%0b wdata=%h, required 0", k, mem_if.mem_we, mem_if.mem_write_data);
            end
            tests++;
            if (mem_if.mem_addr !== b + 16'(k > 15 ? 15 : k)) begin
                fails++;
                $display("FAIL addr_seq k=%0d: got %h, required %h", k, mem_if.mem_addr, b + 16'(k > 15 ? 15 : k));
            end
            tests++;
            if (done !== (k == 17)) begin
                fails++;
                $display("FAIL done_latency k=%0d: got done=%0b, required %0b", k, done, k == 17);
            end
            tests++;
            if (busy !== (k < 17)) begin
                fails++;
                $display("FAIL busy k=%0d: got %0b, required %0b", k, busy, k < 17);
            end
        end
    endtask

    task automatic test_single_hit();
        int k;
        for (int n = 0; n < 16; n++) w[n] = 32'hFFFF_FFFF;
        w[5] = 32'h0000_0ABC;
        load_and_expect(16'h0200, 32'h0000_1000);
        pulse_and_wait(16'h0200, 32'h0000_1000, k);
        tests++;
        if (k != 17) begin
            fails++;
            $display("FAIL single_hit_latency: got %0d edges, required 17", k);
        end
        tests++;
        if (hit_mask !== 16'h0020 || best_nonce !== 4'd5 || best_hash !== 32'h0000_0ABC) begin
            fails++;
            $display("FAIL single_hit: got mask=%h bn=%0d bh=%h, required 0020 5 00000abc", hit_mask, best_nonce, best_hash);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || hit_mask !== 16'h0020) begin
            fails++;
            $display("FAIL hold_after_done: got done=%0b mask=%h, required 0 0020", done, hit_mask);
        end
    endtask

    task automatic test_tie();
        int k;
        for (int n = 0; n < 16; n++) w[n] = 32'h8000_0000;
        w[3] = 32'h0000_0001;
        w[9] = 32'h0000_0001;
        load_and_expect(16'h0300, 32'h0000_0002);
        pulse_and_wait(16'h0300, 32'h0000_0002, k);
        tests++;
        if (k != 17 || hit_mask !== 16'h0208 || best_nonce !== 4'd3) begin
            fails++;
            $display("FAIL tie: got k=%0d mask=%h bn=%0d, required 17 0208 3", k, hit_mask, best_nonce);
        end
    endtask

    task automatic test_strict_and_first();
        int k;
        for (int n = 0; n < 16; n++) w[n] = 32'hFFFF_0000;
        w[0] = 32'h0000_1000;
        load_and_expect(16'h0500, 32'h0000_1000);
        pulse_and_wait(16'h0500, 32'h0000_1000, k);
        tests++;
        if (k != 17 || found !== 1'b0 || hit_mask !== 16'h0 || best_hash !== 32'h0000_1000) begin
            fails++;
            $display("FAIL strict: got k=%0d found=%0b mask=%h bh=%h, required 17 0 0000 00001000", k, found, hit_mask, best_hash);
        end
        for (int n = 0; n < 16; n++) w[n] = 32'hFFFF_FFFF;
        load_and_expect(16'h0600, 32'h0000_1000);
        pulse_and_wait(16'h0600, 32'h0000_1000, k);
        tests++;
        if (k != 17 || best_nonce !== 4'd0 || best_hash !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL all_ones: got k=%0d bn=%0d bh=%h, required 17 0 ffffffff", k, best_nonce, best_hash);
        end
        for (int n = 0; n < 16; n++) w[n] = 32'(n) * 32'h10;
        load_and_expect(16'h0700, 32'h0);
        pulse_and_wait(16'h0700, 32'h0, k);
        tests++;
        if (k != 17 || found !== 1'b0 || hit_count !== 5'd0 || best_hash !== 32'h0) begin
            fails++;
            $display("FAIL target_zero: got k=%0d found=%0b cnt=%0d bh=%h, required 17 0 0 00000000", k, found, hit_count, best_hash);
        end
    endtask

    task automatic test_wrap();
        int k;
        for (int n = 0; n < 16; n++) w[n] = 32'h0000_0100 * 32'(16 - n);
        load_and_expect(16'hFFF8, 32'h0000_0500);
        pulse_and_wait(16'hFFF8, 32'h0000_0500, k);
        tests++;
        if (k != 17 || hit_count !== 5'd4 || best_nonce !== 4'd15) begin
            fails++;
            $display("FAIL wrap: got k=%0d cnt=%0d bn=%0d, required 17 4 15", k, hit_count, best_nonce);
        end
    endtask

    task automatic test_abort();
        int k;
        bit bad;
        for (int n = 0; n < 16; n++) w[n] = 32'hFFFF_FFFF;
        w[5] = 32'h0000_0ABC;
        load_and_expect(16'h0400, 32'h0000_1000);
        output_addr = 16'h0400;
        target = 32'h0000_1000;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        #1;
        tests++;
        if ({busy, done, found, hit_count, hit_mask, best_nonce, best_hash, mem_if.mem_addr} !== '0) begin
            fails++;
            $display("FAIL abort_clear: got busy=%0b done=%0b found=%0b cnt=%0d mask=%h bn=%0d bh=%h addr=%h, required all 0",
                     busy, done, found, hit_count, hit_mask, best_nonce, best_hash, mem_if.mem_addr);
        end
        void'(q.pop_front());
        bad = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i == 3) reset_n = 1'b1;
            if (done) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL abort_no_done: got done=1 after abort, required 0");
        end
        load_and_expect(16'h0400, 32'h0000_1000);
        pulse_and_wait(16'h0400, 32'h0000_1000, k);
        tests++;
        if (k != 17 || hit_mask !== 16'h0020) begin
            fails++;
            $display("FAIL after_abort: got k=%0d mask=%h, required 17 0020", k, hit_mask);
        end
    endtask

    task automatic test_back_to_back();
        int d1 = -1;
        int d2 = -1;
        for (int n = 0; n < 16; n++) w[n] = 32'hFFFF_FFFF;
        w[5] = 32'h0000_0ABC;
        load_and_expect(16'h2000, 32'h0000_1000);
        for (int n = 0; n < 16; n++) w[n] = 32'h9800_0000 - 32'h0100_0000 * 32'(n);
        load_and_expect(16'h3000, 32'h9000_0000);
        output_addr = 16'h2000;
        target = 32'h0000_1000;
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 50; k++) begin
            @(negedge clk);
            if (k == 3) begin
                output_addr = 16'h3000;
                target = 32'h9000_0000;
            end
            if (k == 29) start = 1'b0;
            if (done) begin
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
            if (k == 10) begin
                tests++;
                if (mem_if.mem_addr !== 16'h200A) begin
                    fails++;
                    $display("FAIL b2b_base: got %h, required 200a", mem_if.mem_addr);
                end
            end
            if (k == 18) begin
                tests++;
                if (busy !== 1'b1 || found !== 1'b0 || hit_count !== 5'd0 || hit_mask !== 16'h0 || best_hash !== 32'hFFFF_FFFF || best_nonce !== 4'd0) begin
                    fails++;
                    $display("FAIL b2b_clear: got busy=%0b found=%0b cnt=%0d mask=%h bn=%0d bh=%h, required 1 0 0 0000 0 ffffffff",
                             busy, found, hit_count, hit_mask, best_nonce, best_hash);
                end
            end
        end
        tests++;
        if (d1 != 17 || d2 != 35) begin
            fails++;
            $display("FAIL b2b_dones: got done at %0d and %0d, required 17 and 35", d1, d2);
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL pending_results: got %0d outstanding, required 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_no_hits();
        test_single_hit();
        test_tie();
        test_strict_and_first();
        test_wrap();
        test_abort();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
